// File: rtl/fetch_ctl_pkg.sv
// fetch_ctl_pkg: shared definitions for the fetch sequencer and its branch
// predictor: FSM state encoding, RISC-V opcode constants, reset PC and the
// small arithmetic helpers used for next-PC computation.
package fetch_ctl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // Instruction length in bytes: 4 for a full-width encoding, 2 for compressed.
    function automatic logic [63:0] ilen_bytes(input logic [1:0] ir_lo);
        return (ir_lo == 2'b11) ? 64'd4 : 64'd2;
    endfunction

    // Sign-extend a 13-bit branch offset to 64 bits.
    function automatic logic [63:0] sext13(input logic [12:0] offs);
        return {{51{offs[12]}}, offs};
    endfunction

endpackage

// File: rtl/fetch_ctl_bpu.sv
// bpu: static backward-taken/forward-not-taken predictor. JAL is always
// taken to its PC-relative target; a conditional branch is predicted taken
// when its offset is negative (loop back-edge).
module bpu
    import fetch_ctl_pkg::*;
(
    input  logic        rst_n,
    input  logic [31:0] bp_ir,
    input  logic [63:0] bp_pc,
    output logic        jal_taken,
    output logic [63:0] jal_addr,
    output logic        pr_taken,
    output logic [12:0] pr_offs
);

    logic [20:0] w_j_imm;
    logic [12:0] w_b_imm;

    // Decode the immediates and derive the prediction for the current instruction
    always_comb begin
        w_j_imm   = {bp_ir[31], bp_ir[19:12], bp_ir[20], bp_ir[30:21], 1'b0};
        w_b_imm   = {bp_ir[31], bp_ir[7], bp_ir[30:25], bp_ir[11:8], 1'b0};
        jal_taken = rst_n & (bp_ir[6:0] == OPC_JAL);
        jal_addr  = bp_pc + {{43{w_j_imm[20]}}, w_j_imm};
        pr_taken  = rst_n & (bp_ir[6:0] == OPC_BRANCH) & w_b_imm[12];
        pr_offs   = w_b_imm;
    end

endmodule

// File: rtl/fetch_ctl.sv
// fetch_ctl: fetch sequencer for the hart front end. Owns the fetch PC,
// issues single-outstanding requests, fills the decode slot and handles
// trap / mispredict redirects (in-flight responses are discarded).
// Optional feature: define RV6_BPU_STATS_EN to build the 64-bit branch and
// mispredict counters; otherwise stat_br/stat_mp read as zero.
module fetch_ctl
    import fetch_ctl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_req,
    output logic [63:0] if_addr,
    input  logic        if_ack,
    input  logic        if_rsp_vld,
    input  logic [31:0] if_rsp_ir,
    output logic        if_rsp_rdy,
    output logic        id_vld,
    output logic [31:0] id_ir,
    output logic [63:0] id_pc,
    output logic        id_pred,
    input  logic        id_stall,
    input  logic        ex_br_vld,
    input  logic        ex_br_pred,
    input  logic        ex_br_taken,
    input  logic [63:0] ex_br_target,
    input  logic [63:0] ex_br_fallthru,
    input  logic        trap_vld,
    input  logic [63:0] trap_addr,
    output logic        flush,
    output logic [63:0] stat_br,
    output logic [63:0] stat_mp
);

    fetch_state_e r_state;
    logic [63:0]  r_pc;
    logic         r_id_vld;
    logic [31:0]  r_id_ir;
    logic [63:0]  r_id_pc;
    logic         r_id_pred;

    logic         w_mp;
    logic         w_redir;
    logic [63:0]  w_redir_addr;
    logic         w_slot_busy;
    logic         w_if_req;
    logic         w_if_rsp_rdy;
    logic         w_ack;
    logic         w_rsp_acc;
    logic         w_load;
    logic         w_jal_taken;
    logic [63:0]  w_jal_addr;
    logic         w_pr_taken;
    logic [12:0]  w_pr_offs;
    logic [63:0]  w_next_pc;

    bpu u_bpu (
        .rst_n     (~rst),
        .bp_ir     (if_rsp_ir),
        .bp_pc     (r_pc),
        .jal_taken (w_jal_taken),
        .jal_addr  (w_jal_addr),
        .pr_taken  (w_pr_taken),
        .pr_offs   (w_pr_offs)
    );

    // Redirect detection; a trap wins over a simultaneous mispredict
    always_comb begin
        w_mp    = ex_br_vld & (ex_br_pred != ex_br_taken);
        w_redir = trap_vld | w_mp;
        if (trap_vld) begin
            w_redir_addr = trap_addr;
        end else if (ex_br_taken) begin
            w_redir_addr = ex_br_target;
        end else begin
            w_redir_addr = ex_br_fallthru;
        end
    end

    // Memory handshake: back-pressure from a full, stalled decode slot
    always_comb begin
        w_slot_busy  = r_id_vld & id_stall;
        w_if_req     = 1'b0;
        w_if_rsp_rdy = 1'b0;
        case (r_state)
            ST_REQ:  w_if_req     = ~w_slot_busy;
            ST_WAIT: w_if_rsp_rdy = ~w_slot_busy;
            ST_DROP: w_if_rsp_rdy = 1'b1;
            default: begin
                w_if_req     = 1'b0;
                w_if_rsp_rdy = 1'b0;
            end
        endcase
        w_ack     = w_if_req & if_ack;
        w_rsp_acc = w_if_rsp_rdy & if_rsp_vld;
        w_load    = (r_state == ST_WAIT) & w_rsp_acc & ~w_redir;
    end

    // Next sequential/predicted PC for the instruction being accepted
    always_comb begin
        if (w_jal_taken) begin
            w_next_pc = w_jal_addr;
        end else if (w_pr_taken) begin
            w_next_pc = r_pc + sext13(w_pr_offs);
        end else begin
            w_next_pc = r_pc + ilen_bytes(if_rsp_ir[1:0]);
        end
    end

    // Fetch FSM and PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HOLD;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_redir) r_pc <= w_redir_addr;
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_redir) r_pc <= w_redir_addr;
                    if (w_ack) r_state <= w_redir ? ST_DROP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_redir) begin
                        r_pc    <= w_redir_addr;
                        r_state <= w_rsp_acc ? ST_REQ : ST_DROP;
                    end else if (w_rsp_acc) begin
                        r_pc    <= w_next_pc;
                        r_state <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (w_redir) r_pc <= w_redir_addr;
                    if (if_rsp_vld) r_state <= ST_REQ;
                end
                default: r_state <= ST_HOLD;
            endcase
        end
    end

    // Decode slot: load on accepted response, drain when consumed, kill on redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_vld  <= 1'b0;
            r_id_ir   <= 32'd0;
            r_id_pc   <= 64'd0;
            r_id_pred <= 1'b0;
        end else if (w_redir) begin
            r_id_vld <= 1'b0;
        end else if (w_load) begin
            r_id_vld  <= 1'b1;
            r_id_ir   <= if_rsp_ir;
            r_id_pc   <= r_pc;
            r_id_pred <= w_pr_taken;
        end else if (r_id_vld & ~id_stall) begin
            r_id_vld <= 1'b0;
        end
    end

`ifdef RV6_BPU_STATS_EN
    logic [63:0] r_stat_br;
    logic [63:0] r_stat_mp;

    // Branch and mispredict event counters (wrap at 2^64)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_br <= 64'd0;
            r_stat_mp <= 64'd0;
        end else begin
            if (ex_br_vld) r_stat_br <= r_stat_br + 64'd1;
            if (w_mp)      r_stat_mp <= r_stat_mp + 64'd1;
        end
    end

    assign stat_br = r_stat_br;
    assign stat_mp = r_stat_mp;
`else
    assign stat_br = 64'd0;
    assign stat_mp = 64'd0;
`endif

    assign if_req     = w_if_req;
    assign if_addr    = r_pc;
    assign if_rsp_rdy = w_if_rsp_rdy;
    assign flush      = w_redir & ~rst;
    assign id_vld     = r_id_vld;
    assign id_ir      = r_id_ir;
    assign id_pc      = r_id_pc;
    assign id_pred    = r_id_pred;

endmodule

// File: tb/tb_fetch_ctl.sv
// tb_fetch_ctl: directed scenarios plus a randomized run checked against a
// transaction-level model of the fetch stream (expected PC sequence and
// decode-slot contents computed from instruction semantics).
module tb_fetch_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic        if_rsp_vld;
    logic [31:0] if_rsp_ir;
    logic        if_rsp_rdy;
    logic        id_vld;
    logic [31:0] id_ir;
    logic [63:0] id_pc;
    logic        id_pred;
    logic        id_stall;
    logic        ex_br_vld;
    logic        ex_br_pred;
    logic        ex_br_taken;
    logic [63:0] ex_br_target;
    logic [63:0] ex_br_fallthru;
    logic        trap_vld;
    logic [63:0] trap_addr;
    logic        flush;
    logic [63:0] stat_br;
    logic [63:0] stat_mp;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    fetch_ctl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rsp_vld(if_rsp_vld), .if_rsp_ir(if_rsp_ir), .if_rsp_rdy(if_rsp_rdy),
        .id_vld(id_vld), .id_ir(id_ir), .id_pc(id_pc), .id_pred(id_pred),
        .id_stall(id_stall),
        .ex_br_vld(ex_br_vld), .ex_br_pred(ex_br_pred), .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target), .ex_br_fallthru(ex_br_fallthru),
        .trap_vld(trap_vld), .trap_addr(trap_addr),
        .flush(flush), .stat_br(stat_br), .stat_mp(stat_mp)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        if_ack = 1'b0; if_rsp_vld = 1'b0; if_rsp_ir = 32'd0; id_stall = 1'b0;
        ex_br_vld = 1'b0; ex_br_pred = 1'b0; ex_br_taken = 1'b0;
        ex_br_target = 64'd0; ex_br_fallthru = 64'd0;
        trap_vld = 1'b0; trap_addr = 64'd0;
    endtask

    // One request/response pair with immediate ack and next-cycle response
    task automatic do_fetch(input logic [31:0] ir, input logic [63:0] exp_addr, input string name);
        int n;
        n = 0;
        nxt();
        if_ack = 1'b1;
        #1;
        while (!if_req && n < 20) begin
            nxt();
            #1;
            n++;
        end
        checks++;
        if (if_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req_timeout: if_req=%b required 1 within 20 cycles", name, if_req);
        end
        checks++;
        if (if_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_addr: if_addr=%h required %h", name, if_addr, exp_addr);
        end
        nxt();
        if_ack = 1'b0; if_rsp_vld = 1'b1; if_rsp_ir = ir;
        #1;
        nxt();
        if_rsp_vld = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        trap_vld = 1'b1; trap_addr = 64'h1234;
        nxt(); nxt();
        checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL rst_if_req: got %b required 0", if_req); end
        checks++; if (if_rsp_rdy !== 1'b0) begin errors++; $display("FAIL rst_rsp_rdy: got %b required 0", if_rsp_rdy); end
        checks++; if (if_addr !== RST_PC) begin errors++; $display("FAIL rst_if_addr: got %h required %h", if_addr, RST_PC); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b required 0", flush); end
        checks++; if ({id_vld, id_ir, id_pc, id_pred} !== 98'd0) begin errors++; $display("FAIL rst_slot: vld=%b ir=%h pc=%h pred=%b required zeros", id_vld, id_ir, id_pc, id_pred); end
        checks++; if ({stat_br, stat_mp} !== 128'd0) begin errors++; $display("FAIL rst_stats: br=%0d mp=%0d required 0", stat_br, stat_mp); end
        trap_vld = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        do_fetch(32'h0000_0013, 64'h8000_0000, "seq0");
        checks++; if (id_vld !== 1'b1 || id_pc !== 64'h8000_0000 || id_ir !== 32'h13 || id_pred !== 1'b0) begin
            errors++; $display("FAIL seq0_slot: vld=%b pc=%h ir=%h pred=%b required 1/80000000/00000013/0", id_vld, id_pc, id_ir, id_pred); end
        do_fetch(32'h0000_0001, 64'h8000_0004, "seq1");
        checks++; if (id_pc !== 64'h8000_0004 || id_ir !== 32'h1) begin
            errors++; $display("FAIL seq1_slot: pc=%h ir=%h required 80000004/00000001", id_pc, id_ir); end
        do_fetch(32'h0000_0013, 64'h8000_0006, "seq_c2");
    endtask

    task automatic test_branch_pred();
        do_fetch(32'h0000_0013, 64'h8000_000A, "bp0");
        do_fetch(32'h0000_0001, 64'h8000_000E, "bp1");
        do_fetch(32'hFE00_0EE3, 64'h8000_0010, "bp_beq");
        checks++; if (id_pred !== 1'b1 || id_pc !== 64'h8000_0010) begin
            errors++; $display("FAIL bp_pred: pred=%b pc=%h required 1/80000010", id_pred, id_pc); end
        do_fetch(32'h0000_0013, 64'h8000_000C, "bp_target");
    endtask

    task automatic test_stall();
        logic [63:0] pc0;
        logic [31:0] ir0;
        pc0 = id_pc; ir0 = id_ir;
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL stall_req_%0d: if_req=%b required 0", i, if_req); end
            checks++; if (id_vld !== 1'b1 || id_pc !== pc0 || id_ir !== ir0) begin
                errors++; $display("FAIL stall_slot_%0d: vld=%b pc=%h ir=%h required 1/%h/%h", i, id_vld, id_pc, id_ir, pc0, ir0); end
            nxt();
        end
        id_stall = 1'b0;
        #1;
        checks++; if (if_req !== 1'b1) begin errors++; $display("FAIL stall_release: if_req=%b required 1", if_req); end
        do_fetch(32'h0000_0013, 64'h8000_0010, "stall_resume");
    endtask

    task automatic test_redirect_wait();
        nxt();
        if_ack = 1'b1;
        #1;
        checks++; if (if_addr !== 64'h8000_0014 || if_req !== 1'b1) begin
            errors++; $display("FAIL rdw_req: req=%b addr=%h required 1/80000014", if_req, if_addr); end
        nxt();
        if_ack = 1'b0;
        ex_br_vld = 1'b1; ex_br_pred = 1'b1; ex_br_taken = 1'b0;
        ex_br_fallthru = 64'h8000_0100; ex_br_target = 64'h1234_5678;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rdw_flush: got %b required 1", flush); end
        nxt();
        ex_br_vld = 1'b0;
        if_rsp_vld = 1'b1; if_rsp_ir = 32'h0000_0013;
        #1;
        checks++; if (if_rsp_rdy !== 1'b1) begin errors++; $display("FAIL rdw_drop_rdy: got %b required 1", if_rsp_rdy); end
        nxt();
        if_rsp_vld = 1'b0;
        #1;
        checks++; if (id_vld !== 1'b0) begin errors++; $display("FAIL rdw_dropped: id_vld=%b required 0", id_vld); end
        checks++; if (if_addr !== 64'h8000_0100) begin errors++; $display("FAIL rdw_addr: got %h required 80000100", if_addr); end
        do_fetch(32'h0000_0013, 64'h8000_0100, "rdw_resume");
    endtask

    task automatic test_trap_mp();
        logic [63:0] b0, m0, eb, em;
        b0 = stat_br; m0 = stat_mp;
        nxt();
        trap_vld = 1'b1; trap_addr = 64'h1000;
        ex_br_vld = 1'b1; ex_br_pred = 1'b0; ex_br_taken = 1'b1; ex_br_target = 64'h2000;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL trap_flush: got %b required 1", flush); end
        nxt();
        clear_in();
        #1;
        checks++; if (if_addr !== 64'h1000) begin errors++; $display("FAIL trap_addr: got %h required 1000", if_addr); end
`ifdef RV6_BPU_STATS_EN
        eb = b0 + 64'd1; em = m0 + 64'd1;
`else
        eb = 64'd0; em = 64'd0;
`endif
        checks++; if (stat_br !== eb || stat_mp !== em) begin
            errors++; $display("FAIL trap_stats: br=%0d mp=%0d required %0d/%0d", stat_br, stat_mp, eb, em); end
        // correctly predicted branch: counted, no redirect
        ex_br_vld = 1'b1; ex_br_pred = 1'b1; ex_br_taken = 1'b1; ex_br_target = 64'h3000;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL okbr_flush: got %b required 0", flush); end
        nxt();
        clear_in();
        #1;
`ifdef RV6_BPU_STATS_EN
        eb = b0 + 64'd2;
`endif
        checks++; if (stat_br !== eb || stat_mp !== em || if_addr !== 64'h1000) begin
            errors++; $display("FAIL okbr_stats: br=%0d mp=%0d addr=%h required %0d/%0d/1000", stat_br, stat_mp, if_addr, eb, em); end
        // mispredict not-taken -> taken redirects to target
        ex_br_vld = 1'b1; ex_br_pred = 1'b0; ex_br_taken = 1'b1; ex_br_target = 64'h8000_0200;
        nxt();
        clear_in();
        do_fetch(32'h0000_0013, 64'h8000_0200, "mp_taken");
        // wrap at the top of the address space
        nxt();
        trap_vld = 1'b1; trap_addr = 64'hFFFF_FFFF_FFFF_FFFE;
        nxt();
        clear_in();
        do_fetch(32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, "wrap0");
        do_fetch(32'h0000_0013, 64'h0, "wrap1");
    endtask

    task automatic test_reset_mid();
        nxt();
        if_ack = 1'b1;
        nxt();
        if_ack = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (if_req !== 1'b0 || if_rsp_rdy !== 1'b0 || if_addr !== RST_PC) begin
            errors++; $display("FAIL rstmid: req=%b rdy=%b addr=%h required 0/0/%h", if_req, if_rsp_rdy, if_addr, RST_PC); end
        if_rsp_vld = 1'b1; if_rsp_ir = 32'h0000_0013;
        nxt(); nxt();
        rst = 1'b0;
        #1;
        checks++; if (if_rsp_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_hold_rdy: got %b required 0", if_rsp_rdy); end
        nxt();
        if_rsp_vld = 1'b0;
        #1;
        checks++; if (id_vld !== 1'b0) begin errors++; $display("FAIL rstmid_late_rsp: id_vld=%b required 0", id_vld); end
        do_fetch(32'h0000_0013, RST_PC, "rstmid_resume");
    endtask

    // Random instruction with its intended successor offset and prediction
    task automatic gen_instr(output logic [31:0] ir, output longint delta, output logic pred);
        logic [31:0] r;
        logic [12:0] o13;
        logic [20:0] o21;
        int          off;
        r = $urandom();
        case ($urandom_range(0, 3))
            0: begin ir = {r[31:7], 7'b0010011}; delta = 4; pred = 1'b0; end
            1: begin ir = {r[31:2], 2'($urandom_range(0, 2))}; delta = 2; pred = 1'b0; end
            2: begin
                off = (int'($urandom_range(0, 4095)) - 2048) * 2;
                o13 = 13'(off);
                ir = {o13[12], o13[10:5], r[24:12], o13[4:1], o13[11], 7'b1100011};
                pred = (off < 0);
                delta = pred ? longint'(off) : 64'sd4;
            end
            default: begin
                off = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                o21 = 21'(off);
                ir = {o21[20], o21[10:1], o21[11], o21[19:12], r[11:7], 7'b1101111};
                delta = longint'(off); pred = 1'b0;
            end
        endcase
    endtask

    task automatic test_random();
        logic [63:0] m_pc, o_addr, s_pc;
        logic [31:0] s_ir, g_ir;
        logic        m_vld, s_pred, g_pred, outstanding, exp_req;
        longint      g_delta;
        rst = 1'b1;
        clear_in();
        nxt();
        rst = 1'b0;
        m_pc = RST_PC; m_vld = 1'b0; outstanding = 1'b0;
        s_pc = 64'd0; s_ir = 32'd0; s_pred = 1'b0;
        g_delta = 0; g_pred = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nxt();
            checks++; if (id_vld !== m_vld) begin errors++; $display("FAIL rnd_vld c%0d: got %b required %b", cyc, id_vld, m_vld); end
            if (m_vld) begin
                checks++; if (id_pc !== s_pc || id_ir !== s_ir || id_pred !== s_pred) begin
                    errors++; $display("FAIL rnd_slot c%0d: pc=%h ir=%h pred=%b required %h/%h/%b", cyc, id_pc, id_ir, id_pred, s_pc, s_ir, s_pred); end
            end
            id_stall = ($urandom_range(0, 9) < 3);
            if_ack = ($urandom_range(0, 9) < 6);
            if_rsp_vld = outstanding && ($urandom_range(0, 9) < 6);
            gen_instr(g_ir, g_delta, g_pred);
            if_rsp_ir = g_ir;
            #1;
            exp_req = !outstanding && !(m_vld && id_stall);
            checks++; if (if_req !== exp_req) begin errors++; $display("FAIL rnd_req c%0d: got %b required %b", cyc, if_req, exp_req); end
            if (outstanding) begin
                checks++; if (if_rsp_rdy !== !(m_vld && id_stall)) begin
                    errors++; $display("FAIL rnd_rdy c%0d: got %b required %b", cyc, if_rsp_rdy, !(m_vld && id_stall)); end
            end
            if (if_req && if_ack) begin
                checks++; if (if_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h required %h", cyc, if_addr, m_pc); end
                outstanding = 1'b1; o_addr = m_pc;
            end
            if (if_rsp_vld && if_rsp_rdy) begin
                outstanding = 1'b0;
                s_pc = o_addr; s_ir = g_ir; s_pred = g_pred;
                m_pc = o_addr + 64'(g_delta);
                m_vld = 1'b1;
            end else if (m_vld && !id_stall) begin
                m_vld = 1'b0;
            end
        end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_pred();
        test_stall();
        test_redirect_wait();
        test_trap_mp();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
